// File: rtl/jtag_host.sv
// ---------------------------------------------------------------------------
// jtag_host
//
// Purpose:
//   Command-driven JTAG master. A command (TAP reset, IR scan, DR scan or a
//   run of idle TCKs) is accepted over a valid/ready handshake. The host then
//   produces the TCK/TMS/TDI waveform and, for scans, captures TDO. It returns
//   the captured bits over a second valid/ready handshake.
//
//   Every command assumes the TAP starts in Run-Test/Idle, and every command
//   leaves it there again. After reset, software issues a TAP_RESET first.
//
// Parameters:
//   CLK_DIV  TCK half-period in clk cycles (1..255); CLK_DIV=1 gives clk/2
//   MAX_LEN  maximum shift length per scan (longer requests are clamped)
//
// Configuration macro:
//   JTAG_HOST_TDO_FALL_EN  when defined, TDO is sampled on the clk edge where
//                          TCK falls at the end of each shift period. When
//                          undefined, TDO is sampled on the edge where TCK
//                          rises within the shift period.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command offered
//   cmd_ready  host can accept a command (IDLE with no pending result)
//   cmd_op     00 TAP_RESET, 01 IR_SCAN, 10 DR_SCAN, 11 IDLE_CYCLES
//   cmd_len    shift length for scans, TCK count for IDLE_CYCLES
//   cmd_data   TDI bits, shifted LSB first
//   rsp_valid  scan result pending
//   rsp_ready  result consumer ready
//   rsp_data   captured TDO bits, zero above the shift length
//   tck/tms/tdi JTAG drive signals
//   tdo        JTAG data from the target
//   busy       high while a TCK sequence is running
// ---------------------------------------------------------------------------
module jtag_host #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [39:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [39:0] rsp_data,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo,
  output logic        busy
);

  localparam logic [1:0] OP_TAP_RESET = 2'b00;
  localparam logic [1:0] OP_IR_SCAN   = 2'b01;
  localparam logic [1:0] OP_DR_SCAN   = 2'b10;
  localparam logic [1:0] OP_IDLE      = 2'b11;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] MAX_L    = 6'(MAX_LEN);

`ifdef JTAG_HOST_TDO_FALL_EN
  localparam bit TDO_ON_FALL = 1'b1;
`else
  localparam bit TDO_ON_FALL = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RST_SEQ,
    HDR,
    SHIFT,
    TRL,
    RSP
  } state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  seq_last;
  logic [5:0]  seq_ones;
  logic [5:0]  len_m1;
  logic        is_ir;
  logic [39:0] data_q;

  logic [5:0]  scan_len;
  logic [5:0]  next_cnt;
  logic        phase_end;
  logic        hdr_done;
  logic        accept;

  // Effective shift length: zero means one bit, and long requests are
  // clamped to what the data registers can hold.
  always_comb begin
    scan_len = cmd_len;
    if (cmd_len == 6'd0) begin
      scan_len = 6'd1;
    end else if (cmd_len > MAX_L) begin
      scan_len = MAX_L;
    end
  end

  assign next_cnt  = bit_cnt + 6'd1;
  assign phase_end = (div_cnt == DIV_LAST);
  // IR header is Select-DR, Select-IR, Capture-IR, Shift-IR (4 periods);
  // DR header skips Select-IR (3 periods).
  assign hdr_done  = is_ir ? (bit_cnt == 6'd3) : (bit_cnt == 6'd2);
  assign cmd_ready = (state == IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;

  // Controller FSM and TCK generator.
  // Every TCK period is CLK_DIV clocks low, then CLK_DIV clocks high. TMS and
  // TDI for the next period are loaded at the edge that drops TCK. For the
  // first period, they are loaded at the acceptance edge instead. That way
  // the target always sees stable values at its rising TCK.
  // RST_SEQ runs both TMS-only sequences. The first seq_ones periods carry
  // TMS=1 and the rest carry TMS=0. So TAP_RESET is 5 ones then a zero, and
  // IDLE_CYCLES is all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      seq_last  <= '0;
      seq_ones  <= '0;
      len_m1    <= '0;
      is_ir     <= 1'b0;
      data_q    <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q   <= cmd_data;
            rsp_data <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tck      <= 1'b0;
            tdi      <= 1'b0;
            case (cmd_op)
              OP_TAP_RESET: begin
                state    <= RST_SEQ;
                seq_last <= 6'd5;
                seq_ones <= 6'd5;
                tms      <= 1'b1;
                busy     <= 1'b1;
              end
              OP_IDLE: begin
                // A zero-length idle run completes at acceptance with no TCK.
                if (cmd_len != 6'd0) begin
                  state    <= RST_SEQ;
                  seq_last <= cmd_len - 6'd1;
                  seq_ones <= 6'd0;
                  tms      <= 1'b0;
                  busy     <= 1'b1;
                end
              end
              OP_IR_SCAN, OP_DR_SCAN: begin
                state  <= HDR;
                is_ir  <= (cmd_op == OP_IR_SCAN);
                len_m1 <= scan_len - 6'd1;
                tms    <= 1'b1;
                busy   <= 1'b1;
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end

        RST_SEQ, HDR, SHIFT, TRL: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!tck) begin
              // Rising TCK: the target shifts, and the host may sample TDO.
              tck <= 1'b1;
              if (!TDO_ON_FALL && state == SHIFT) begin
                rsp_data[bit_cnt] <= tdo;
              end
            end else begin
              // Falling TCK ends the period. Set up the next one or finish.
              tck <= 1'b0;
              if (TDO_ON_FALL && state == SHIFT) begin
                rsp_data[bit_cnt] <= tdo;
              end
              case (state)
                RST_SEQ: begin
                  if (bit_cnt == seq_last) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                  end else begin
                    bit_cnt <= next_cnt;
                    tms     <= (next_cnt < seq_ones);
                  end
                end
                HDR: begin
                  if (hdr_done) begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                    tms     <= (len_m1 == 6'd0);
                    tdi     <= data_q[0];
                  end else begin
                    bit_cnt <= next_cnt;
                    // Only the IR header has a second TMS=1 (Select-IR).
                    tms     <= is_ir && (bit_cnt == 6'd0);
                  end
                end
                SHIFT: begin
                  if (bit_cnt == len_m1) begin
                    state   <= TRL;
                    bit_cnt <= '0;
                    tms     <= 1'b1;
                    tdi     <= 1'b0;
                  end else begin
                    bit_cnt <= next_cnt;
                    tms     <= (next_cnt == len_m1);
                    tdi     <= data_q[next_cnt];
                  end
                end
                TRL: begin
                  if (bit_cnt == 6'd1) begin
                    state     <= RSP;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b1;
                    bit_cnt   <= '0;
                  end else begin
                    bit_cnt <= 6'd1;
                    tms     <= 1'b0;
                  end
                end
                default: begin
                  state <= IDLE;
                end
              endcase
            end
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/jtag_host.md
JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 The module SHALL have parameter CLK_DIV with default 2, meaning the TCK half-period in clk cycles (legal values 1..255).
REQ-002 The module SHALL have parameter MAX_LEN with default 40, meaning the maximum number of shift bits per scan.
REQ-003 Port clk, input, 1 bit: system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port cmd_valid, input, 1 bit: a command is offered.
REQ-006 Port cmd_ready, output, 1 bit: the command is accepted when cmd_valid and cmd_ready are both high.
REQ-007 Port cmd_op, input, 2 bits: 00 TAP_RESET, 01 IR_SCAN, 10 DR_SCAN, 11 IDLE_CYCLES.
REQ-008 Port cmd_len, input, 6 bits: shift length for scans, or TCK count for IDLE_CYCLES.
REQ-009 Port cmd_data, input, 40 bits: TDI data, shifted out LSB first.
REQ-010 Port rsp_valid, output, 1 bit: a scan result is pending.
REQ-011 Port rsp_ready, input, 1 bit: the result is consumed when rsp_valid and rsp_ready are both high.
REQ-012 Port rsp_data, output, 40 bits: captured TDO bits, zero-extended.
REQ-013 Port tck, tms and tdi, each an output of 1 bit: the JTAG drive signals.
REQ-014 Port tdo, input, 1 bit: JTAG TDO from the target.
REQ-015 Port busy, output, 1 bit: high while a TCK sequence is in progress.

Function
REQ-016 TCK timing SHALL be as follows: tck idles low; each TCK period is a low phase of CLK_DIV clk cycles followed by a high phase of CLK_DIV clk cycles.
REQ-017 tms and tdi SHALL change only at the clk edge where tck falls, or at the start of the low phase of the first period.
REQ-018 The controller FSM SHALL use the states IDLE, RST_SEQ, HDR, SHIFT, TRL, RSP.
REQ-019 cmd_ready SHALL be high exactly when the FSM is in IDLE and rsp_valid is low.
REQ-020 A command accepted in IDLE SHALL start its first TCK low phase on the next clk cycle, and busy SHALL rise in that same cycle.
REQ-021 TAP_RESET SHALL produce 6 TCK periods with TMS sequence 1,1,1,1,1,0, ending in Run-Test/Idle; no response is produced.
REQ-022 IDLE_CYCLES SHALL produce cmd_len TCK periods with TMS=0, and cmd_len=0 SHALL produce zero periods (command completes immediately); no response is produced.
REQ-023 DR_SCAN SHALL produce header TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR), then L shift periods, then trailer TMS 1,0, for a total of L+5 TCK periods.
REQ-024 IR_SCAN SHALL produce header TMS 1,1,0,0, then L shift periods, then trailer TMS 1,0, for a total of L+6 TCK periods.
REQ-025 During the L shift periods, TMS SHALL be 0 for all but the last shift period and 1 on the last (Exit1).
REQ-026 In shift period i, tdi SHALL equal cmd_data[i], latched at command acceptance.
REQ-027 L SHALL be cmd_len, with 0 treated as 1 and any value above MAX_LEN clamped to MAX_LEN.
REQ-028 tdo SHALL be sampled on the clk edge where tck rises in shift period i, and the sample SHALL be stored in rsp_data[i].
REQ-029 rsp_data bits at and above L SHALL be 0.
REQ-030 After the last trailer period, busy SHALL fall and the FSM SHALL enter RSP, with rsp_valid high and rsp_data stable until rsp_ready is high.
REQ-031 A result SHALL be consumed when rsp_valid and rsp_ready are both high, after which the FSM returns to IDLE on the next clk; rsp_ready asserted with rsp_valid low SHALL be ignored.
REQ-032 cmd_valid asserted while cmd_ready is low SHALL have no effect, and the command SHALL be held by the source.
REQ-033 The host SHALL assume the TAP is in Run-Test/Idle at the start of every command, so software SHALL issue TAP_RESET first after rst_n.
REQ-034 The bit counter and TCK divider counter SHALL not wrap, and CLK_DIV=1 SHALL yield tck = clk/2.

Reset
REQ-035 Asserting rst_n SHALL asynchronously force FSM=IDLE, tck=0, tms=1, tdi=0, busy=0, rsp_valid=0, rsp_data=0, and clear all counters.
REQ-036 After rst_n deasserts, cmd_ready SHALL be 1.
REQ-037 Assertion of rst_n mid-scan SHALL abort the scan immediately, and no response SHALL be produced for the aborted scan.

Configuration
REQ-038 When macro JTAG_HOST_TDO_FALL_EN is defined, tdo SHALL be sampled on the clk edge where tck falls at the end of each shift period instead of the rising edge, with all other timing unchanged.
REQ-039 When JTAG_HOST_TDO_FALL_EN is undefined, rising-edge sampling per REQ-028 SHALL apply.

Verification
REQ-040 Bench scenario: CLK_DIV=2, TAP_RESET -> exactly 6 tck pulses each 4 clk long, TMS 1,1,1,1,1,0, busy high 24 clk, no rsp_valid.
REQ-041 Bench scenario: IR_SCAN L=5 data 0x11 against a TAP model with IR capture value 5'b00001 -> 11 TCK periods, TMS 1,1,0,0,0,0,0,0,1,1,0, TDI 1,0,0,0,1, rsp_data=0x01.
REQ-042 Bench scenario: DR_SCAN L=32 data 0 after IDCODE is selected, model IDCODE 0x12345678 -> 37 TCK periods, rsp_data=0x0012345678.
REQ-043 Bench scenario: cmd_len=0 and cmd_len=63 DR_SCAN -> 6 and 45 TCK periods respectively, with rsp_data bits at and above L equal to 0.
REQ-044 Bench scenario: rsp_ready held low for 10 clk after rsp_valid -> rsp_data is stable, cmd_ready stays 0, and a second cmd_valid is ignored until the handshake completes.
REQ-045 Bench scenario: rst_n pulsed during shift bit 10 of a DR scan -> tck=0, tms=1, busy=0, and no rsp_valid; the subsequent TAP_RESET then behaves per REQ-040.
